regfile_multiport: RTL and testbench

//  Parametrised multi-port integer register file for the RV32 core: NUM_RD registered read

---
 rtl/regfile_multiport.sv | 111 +++++++++++
 tb/tb_regfile_multiport.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port integer register file: registered reads, optional write bypass,
// hardwired x0 and a same-address write conflict flag.
module regfile_multiport #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic [NUM_RD-1:0]      rd_en,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic                   wr_conf
);

    logic [XLEN-1:0] mem [NUM_REGS];

    logic [NUM_WR-1:0] we_eff;
    logic [AW-1:0]     wa [NUM_WR];
    logic [XLEN-1:0]   wd [NUM_WR];
    logic [AW-1:0]     ra [NUM_RD];
    logic [XLEN-1:0]   rd_next [NUM_RD];
    logic [XLEN-1:0]   rd_q [NUM_RD];
    logic              conf_next;

    genvar gp;
    genvar gq;

    for (gp = 0; gp < NUM_WR; gp++) begin : g_wr
        assign wa[gp] = wr_addr[gp*AW +: AW];
        assign wd[gp] = wr_data[gp*XLEN +: XLEN];
        // a write to x0 is dropped entirely when x0 is hardwired
        assign we_eff[gp] = wr_en[gp] &&
                            !((ZERO_REG != 0) && (wa[gp] == '0));
    end

    for (gq = 0; gq < NUM_RD; gq++) begin : g_rd
        assign ra[gq] = rd_addr[gq*AW +: AW];
        assign rd_data[gq*XLEN +: XLEN] = rd_q[gq];
    end

    if (NUM_WR == 2) begin : g_conf
        assign conf_next = we_eff[0] && we_eff[1] && (wa[0] == wa[1]);
    end else begin : g_noconf
        assign conf_next = 1'b0;
    end

    // read value per port: stored contents, overridden by a matching write
    always_comb begin
        for (int q = 0; q < NUM_RD; q++) begin
            rd_next[q] = mem[ra[q]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (we_eff[p] && (wa[p] == ra[q])) begin
                        rd_next[q] = wd[p];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra[q] == '0)) begin
                rd_next[q] = '0;
            end
        end
    end

    // register array update; higher port index is applied last and wins
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we_eff[p]) begin
                    mem[wa[p]] <= wd[p];
                end
            end
        end
    end

    // read data registers hold their value while the port is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_RD; q++) begin
                rd_q[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_RD; q++) begin
                if (rd_en[q]) begin
                    rd_q[q] <= rd_next[q];
                end
            end
        end
    end

    // one-cycle flag for two ports writing the same live register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_conf <= 1'b0;
        end else begin
            wr_conf <= conf_next;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: two instances (bypass on/off)
// share stimulus and are checked against an array-based reference model.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b;
    logic [63:0] rd_data_n;
    logic        conf_b;
    logic        conf_n;

    always #5 clk = ~clk;

    regfile_multiport #(
        .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(1), .ZERO_REG(1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .wr_conf(conf_b)
    );

    regfile_multiport #(
        .XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(0), .ZERO_REG(1)
    ) u_nb (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_n), .wr_conf(conf_n)
    );

    typedef struct {
        int unsigned edge_n;
        logic [31:0] b0, b1, n0, n1;
        logic        conf;
    } exp_t;

    exp_t sb[$];
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [32];
    logic [31:0] hb [2];
    logic [31:0] hn [2];
    logic        mconf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // monitor: compare each edge's registered outputs with its queued entry
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_n == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("rd0_byp", rd_data_b[31:0], e.b0);
            check("rd1_byp", rd_data_b[63:32], e.b1);
            check("rd0_nobyp", rd_data_n[31:0], e.n0);
            check("rd1_nobyp", rd_data_n[63:32], e.n1);
            check("conf_byp", {31'd0, conf_b}, {31'd0, e.conf});
            check("conf_nobyp", {31'd0, conf_n}, {31'd0, e.conf});
        end
    end

    // reference: registers as an array, writes applied after reads sample
    task automatic model(input logic rst, input logic [1:0] we,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] re,
                         input logic [4:0] r0, input logic [4:0] r1);
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        bit          live [2];
        wa[0] = a0; wa[1] = a1;
        wd[0] = d0; wd[1] = d1;
        ra[0] = r0; ra[1] = r1;
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
            for (int q = 0; q < 2; q++) begin
                hb[q] = 32'd0;
                hn[q] = 32'd0;
            end
            mconf = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) live[p] = we[p] && (wa[p] != 5'd0);
            for (int q = 0; q < 2; q++) begin
                if (re[q]) begin
                    hn[q] = mdl[ra[q]];
                    hb[q] = mdl[ra[q]];
                    for (int p = 0; p < 2; p++)
                        if (live[p] && wa[p] == ra[q]) hb[q] = wd[p];
                    if (ra[q] == 5'd0) hb[q] = 32'd0;
                end
            end
            for (int p = 0; p < 2; p++)
                if (live[p]) mdl[wa[p]] = wd[p];
            mconf = live[0] && live[1] && (wa[0] == wa[1]);
        end
    endtask

    // drive one cycle, record its expected result, advance past the edge
    task automatic step(input logic rst, input logic [1:0] we,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [1:0] re,
                        input logic [4:0] r0, input logic [4:0] r1);
        exp_t e;
        reset   = rst;
        wr_en   = we;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
        rd_en   = re;
        rd_addr = {r1, r0};
        model(rst, we, a0, a1, d0, d1, re, r0, r1);
        e.edge_n = cyc + 1;
        e.b0 = hb[0]; e.b1 = hb[1];
        e.n0 = hn[0]; e.n1 = hn[1];
        e.conf = mconf;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    endtask

    initial begin
        int waited;
        // reset, then every address reads zero
        step(1'b1, 2'b11, 5'd3, 32'h99, 5'd4, 32'h98, 2'b11, 5'd3, 5'd4);
        step(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++)
            step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'(a), 5'd0);
        // write then read, then hold with read disabled
        step(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'd5, 5'd0);
        idle(); idle(); idle();
        // x0 write with same-cycle read, then plain read of x0
        step(1'b0, 2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 2'b11, 5'd0, 5'd0);
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd0);
        // bypass versus old value on x7
        step(1'b0, 2'b01, 5'd7, 32'h11, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        step(1'b0, 2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'd0, 2'b11, 5'd7, 5'd7);
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b01, 5'd7, 5'd0);
        // collision on x9: port 1 wins, flag for one cycle
        step(1'b0, 2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 2'b01, 5'd9, 5'd0);
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'd9, 5'd9);
        idle();
        // distinct addresses, then both ports writing x0
        step(1'b0, 2'b11, 5'd3, 32'h3, 5'd4, 32'h4, 2'b00, 5'd0, 5'd0);
        step(1'b0, 2'b11, 5'd0, 32'h5, 5'd0, 32'h6, 2'b11, 5'd3, 5'd4);
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd3);
        // reset overrides a read of x10 and a write to x11
        step(1'b0, 2'b01, 5'd10, 32'hFF, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        step(1'b1, 2'b10, 5'd0, 32'd0, 5'd11, 32'h7, 2'b01, 5'd10, 5'd0);
        step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11, 5'd10, 5'd11);
        // random back-to-back traffic, small address range for collisions
        for (int i = 0; i < 400; i++) begin
            logic [4:0] m;
            m = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            step(($urandom_range(0, 63) == 0),
                 2'($urandom), 5'($urandom) & m, $urandom,
                 5'($urandom) & m, $urandom,
                 2'($urandom), 5'($urandom) & m, 5'($urandom) & m);
        end
        idle();
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
